// File: rtl/receive.sv
// Serial byte receiver: low start bit, 8 data bits LSB first, one-cycle word_valid strobe.
// Optional RX_STOP_CHECK_EN adds a checked high stop bit with a framing_error pulse.
module receive #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connection_status,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       word_valid,
  output logic       receive_busy,
  output logic       framing_error
);
  localparam int         HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] RELOAD    = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_M1   = (HALF > 0) ? 8'(HALF - 1) : 8'd0;

`ifdef RX_STOP_CHECK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, DONE, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
`endif

  state_t     r_state;
  logic [1:0] r_sync;
  logic [7:0] r_timer;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_word;
  logic       r_word_valid;
  logic       w_s;

  assign w_s = r_sync[1];

`ifdef RX_STOP_CHECK_EN
  logic r_framing_error;
  assign framing_error = r_framing_error;
`else
  assign framing_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync       <= 2'b11;
      r_state      <= IDLE;
      r_timer      <= 8'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_word       <= 8'd0;
      r_word_valid <= 1'b0;
`ifdef RX_STOP_CHECK_EN
      r_framing_error <= 1'b0;
`endif
    end else begin
      r_sync       <= {r_sync[0], rxd};
      r_word_valid <= 1'b0;
`ifdef RX_STOP_CHECK_EN
      r_framing_error <= 1'b0;
`endif
      if (!connection_status) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_s) begin
              r_bit_idx <= 3'd0;
              // Mid-start already reached at t0 for very short bit periods.
              if (HALF == 0) begin
                r_state <= DATA;
                r_timer <= RELOAD;
              end else begin
                r_state <= START;
                r_timer <= HALF_M1;
              end
            end
          end
          START: begin
            if (r_timer != 8'd0) begin
              r_timer <= r_timer - 8'd1;
            end else if (w_s) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_timer <= RELOAD;
            end
          end
          DATA: begin
            if (r_timer != 8'd0) begin
              r_timer <= r_timer - 8'd1;
            end else begin
              r_shift   <= {w_s, r_shift[7:1]};
              r_timer   <= RELOAD;
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
`ifdef RX_STOP_CHECK_EN
                r_state <= STOP;
`else
                r_state <= DONE;
`endif
              end
            end
          end
`ifdef RX_STOP_CHECK_EN
          STOP: begin
            if (r_timer != 8'd0) begin
              r_timer <= r_timer - 8'd1;
            end else if (w_s) begin
              r_state <= DONE;
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= WAIT_HIGH;
            end
          end
          // A stuck-low line must return high before a new start is accepted.
          WAIT_HIGH: begin
            if (w_s) r_state <= IDLE;
          end
`endif
          DONE: begin
            r_word       <= r_shift;
            r_word_valid <= 1'b1;
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign word         = r_word;
  assign word_valid   = r_word_valid;
  assign receive_busy = (r_state != IDLE);
endmodule

// File: doc/receive.md
# receive

Serial byte receiver, the counterpart of the team's serial transmitter. It recovers frames from the `rxd` line: low start bit, then 8 data bits LSB first, with an optional high stop bit. Each byte is presented on a parallel output with a one-cycle valid strobe. The block sits between the link pin and the byte consumer and is gated by the same `connection_status` signal as the transmitter.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Range 1..255. Default 1 matches the transmitter's one-bit-per-clock rate.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset (`rst == 0` resets on the next `clk` edge).
- `connection_status` input 1: link enable; 0 aborts and holds the receiver idle.
- `rxd` input 1: serial line; idles high.
- `word` output 8: last correctly received byte; holds its value until the next good frame.
- `word_valid` output 1: one-cycle pulse when `word` is updated.
- `receive_busy` output 1: high whenever the FSM is not in IDLE.
- `framing_error` output 1: one-cycle pulse on a bad stop bit. Tied to 0 without `RX_STOP_CHECK_EN`.

## Operation
- `rxd` passes through a 2-flop synchronizer; its output is `s`. Synchronizer flops reset to 1.
- Counters:
  - `timer`: 8 bits, counts down, reloads to `CLKS_PER_BIT-1`.
  - `bit_idx`: 3 bits, 0..7.
  - Shift register: 8 bits, shifts right, new bit inserted at [7]. After 8 bits, bit 0 holds the first data bit.
- States:
  - **IDLE**: on `s == 0`, this cycle is t0.
    - If `CLKS_PER_BIT == 1`, go to DATA with `timer = 0`.
    - Otherwise go to START with `timer = (CLKS_PER_BIT-1)/2 - 1`. If that value is negative, the START check happens at t0 itself, i.e. go directly to DATA.
  - **START**: when `timer` reaches 0, sample `s` (mid-start).
    - `s == 1`: glitch; return to IDLE with no outputs.
    - `s == 0`: go to DATA with `timer = CLKS_PER_BIT-1`.
  - **DATA**: when `timer` reaches 0, shift in `s` and reload `timer`.
    - Data bit k is sampled at cycle t0 + floor((CLKS_PER_BIT-1)/2) + (k+1)·CLKS_PER_BIT.
    - After bit 7: go to DONE, or to STOP if `RX_STOP_CHECK_EN` is defined.
  - **STOP** (macro only): sample `s` at t0 + floor((CLKS_PER_BIT-1)/2) + 9·CLKS_PER_BIT.
    - `s == 1`: go to DONE.
    - `s == 0`: pulse `framing_error`, leave `word` unchanged, go to WAIT_HIGH.
  - **DONE**: load `word` from the shift register, pulse `word_valid`, return to IDLE. A start bit is accepted on the following cycle.
  - **WAIT_HIGH**: stay until `s == 1`, then go to IDLE. This prevents a stuck-low line from retriggering.
- `connection_status == 0`: next state is IDLE. Any partial frame is discarded with no `word_valid` or `framing_error`. The synchronizer keeps running.
- Reset (`rst == 0`), all outputs:
  - `word` = 0
  - `word_valid` = 0
  - `receive_busy` = 0
  - `framing_error` = 0
  - FSM in IDLE, counters 0, synchronizer flops 1.
- Reset and `connection_status` both take priority over any in-progress frame, on any cycle.

## Timing
- Pin-to-`s` latency: 2 cycles.
- `word_valid` and the `word` update occur on the edge one cycle after the last sample edge (bit 7, or the stop bit with the macro).
- With `CLKS_PER_BIT = 1` and no macro:
  - `word_valid` is high during the cycle after edge t0+9.
  - Back-to-back frames are accepted with at least one idle-state cycle between frames. The DONE cycle provides this; the receiver is ready again at t0+10.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `word_valid` and `framing_error` are never high in the same cycle, and never high for more than one cycle.

## Configuration
- Macro: `RX_STOP_CHECK_EN`.
- **Defined**: the STOP and WAIT_HIGH states exist. A stop bit must be high. A low stop bit pulses `framing_error` and drops the byte. Frame length is 10 bit periods.
- **Undefined**: frame length is 9 bit periods (start + 8 data), matching the transmitter's stop-less framing. STOP and WAIT_HIGH are removed and `framing_error` is constant 0.

## Test plan
- **Reset**: hold `rst = 0` for 3 cycles with `rxd` toggling. All outputs are 0 and no `word_valid` occurs. Release reset; `rxd` held 1 produces no activity for 20 cycles.
- **Single byte** (`CLKS_PER_BIT = 1`, no macro): drive 0 then 1,0,1,0,0,1,0,1. Result: `word = 8'hA5`, `word_valid` high for exactly 1 cycle, `receive_busy` high from t0+1 until `word_valid`.
- **Oversampled**:
  - With `CLKS_PER_BIT = 8`, send 8'h3C with each bit held 8 cycles. Result: `word = 8'h3C`.
  - A 3-cycle low glitch on idle `rxd` returns the FSM to IDLE with no `word_valid`.
- **Abort**: drop `connection_status` during data bit 4 of 8'hFF, then restore it and send 8'h12. Result: exactly one `word_valid`, with `word = 8'h12`.
- **Framing** (`RX_STOP_CHECK_EN`): send 8'h55 with a low stop bit and hold `rxd` low for 20 cycles.
  - Result: one `framing_error` pulse, `word` unchanged, no restart until `rxd` goes high.
  - A following good 8'h81 frame yields `word = 8'h81`.
- **Back-to-back** (`CLKS_PER_BIT = 1`, no macro): send 8'h00, 8'hFF, 8'h7E with one idle-high cycle between frames. Result: three `word_valid` pulses, 10 cycles apart, carrying those values in order.
